tx_dmac: RTL
============

TX_DMAC -- requirements
Module: tx_dmac
Interface
REQ-001 ADDR_W, 48: AXI address width.
REQ-002 clk  in  1  clock clk; all logic on rising edge.
REQ-003 rst_n  in  1  reset rst_n, synchronous, active-low.
REQ-004 read_enable  in  1  keep read loop running while high.
REQ-005 read_state  out  3  current FSM state code.
REQ-006 read_error  out  1  sticky error: rresp[1] seen or rlast on wrong beat.
REQ-007 buffer_base_address  in  ADDR_W  ring base in DDR, 16-byte aligned.
REQ-008 buffer_size  in  32  ring size in bytes, multiple of burst bytes.
REQ-009 buffer_packet_size_bytes  in  17  bytes host deposits per packet.
REQ-010 buffer_packet_tick  in  1  host strobe: one packet written into ring.
REQ-011 buffer_packet_tick_ack  out  1  tick accepted; not self-clearing.
REQ-012 buffer_occupation  out  32  unread bytes in ring.
REQ-013 burst_length_set  in  9  beats per burst, 1..256.
REQ-014 burst_counter  out  32  completed bursts since leaving IDLE.
REQ-015 tx_fifo_space_ready  in  1  downstream TX FIFO can absorb one full burst.
REQ-016 m_axis_tx_tdata  out  128  stream data.
REQ-017 m_axis_tx_tvalid  out  1  stream valid.
REQ-018 m_axis_tx_tready  in  1  stream ready.
REQ-019 m_axi_araddr  out  ADDR_W  read burst address.
REQ-020 m_axi_arlen  out  8  burst_length_set-1, combinational.
REQ-021 m_axi_arvalid  out  1  AR valid.
REQ-022 m_axi_arready  in  1  AR ready.
REQ-023 m_axi_rdata  in  128  read data.
REQ-024 m_axi_rresp  in  2  read response.
REQ-025 m_axi_rlast  in  1  last beat.
REQ-026 m_axi_rvalid  in  1  R valid.
REQ-027 m_axi_rready  out  1  R ready.
Function
REQ-028 burst_bytes SHALL equal burst_length_set*16, 13 bits, zero-extended for 32-bit arithmetic.
REQ-029 FSM SHALL have IDLE=0, CHECK=1, ADDR=2, DATA=3; any other code SHALL go to IDLE next cycle.
REQ-030 IDLE: araddr<=base, burst_counter<=0, read_error<=0, arvalid=0; go CHECK when read_enable high.
REQ-031 CHECK: !read_enable -> IDLE; else if occupation>=burst_bytes, tx_fifo_space_ready and !read_error, arvalid=1 next cycle and go ADDR.
REQ-032 ADDR: arvalid/araddr held stable until arready; on handshake arvalid<=0, araddr<=araddr+burst_bytes, wrapped to base when result >= base+buffer_size, go DATA.
REQ-033 DATA: rready=tx_tready, tx_tvalid=rvalid, tx_tdata=rdata combinationally (zero latency, no storage); rready and tx_tvalid SHALL be 0 outside DATA.
REQ-034 DATA: beat index counts handshakes; on handshaked rlast burst_counter+1 and go CHECK; rresp[1] on any beat or rlast with index!=arlen SHALL set read_error, burst still drains to rlast.
REQ-035 occupation SHALL decrease by burst_bytes in the AR handshake cycle.
REQ-036 tick high with ack low SHALL add packet bytes and set ack only if occupation+packet<=buffer_size; otherwise tick waits, ack low; ack clears the cycle after tick low.
REQ-037 Tick add and AR decrement in the same cycle SHALL both apply (net change).
REQ-038 read_enable low in ADDR/DATA SHALL let current burst finish, then CHECK -> IDLE; AR never withdrawn.
Reset
REQ-039 On reset: state IDLE, araddr=buffer_base_address, all other registered outputs 0, occupation 0.
REQ-040 Reset mid-burst SHALL abort at the next edge (arvalid, rready low); no drain, interconnect resets together.
Structure
REQ-041 Package tx_dmac_pkg SHALL hold the state enum, BEAT_BYTES=16, DATA_W=128.
REQ-042 Sub-module tx_dmac_occupancy SHALL own occupation and tick handshake; top owns FSM and address.
Verification
REQ-043 base=0x1000_0000, size=4096, len=16, pkt=1024, one tick -> ack 1, occupation 1024; four ARs 0x1000_0000..0x1000_0300, 64 beats out, burst_counter 4, occupation 0.
REQ-044 size=512, len=16, pkt=256, three ticks spaced -> araddr sequence base, base+0x100, base (wrap).
REQ-045 tx_tready low 10 cycles mid-burst -> rready low same cycles, all 16 beats delivered in order, none duplicated.
REQ-046 size=1024, occupation 1024, tick pkt=256, fifo ready 0 -> ack 0; fifo ready 1 -> after AR occupation 768, then ack 1, occupation 1024.
REQ-047 rresp=2 on beat 5 -> read_error 1, 16 beats drained, no new AR; read_enable low then high -> read_error 0, reads resume.

Source files
------------

// File: rtl/tx_dmac_pkg.sv
// Shared types and constants for the TX DMA read engine.
package tx_dmac_pkg;

    localparam int BEAT_BYTES = 16;
    localparam int DATA_W     = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3
    } state_t;

    // Bytes moved by one burst; at most 256*16 = 4096, so it fits in 13 bits.
    function automatic logic [31:0] burst_bytes_of(input logic [8:0] len);
        return 32'(len) * 32'(BEAT_BYTES);
    endfunction

endpackage

// File: rtl/tx_dmac_occupancy.sv
// Ring fill tracker: host packet ticks add bytes, accepted read bursts remove them.
module tx_dmac_occupancy
    import tx_dmac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] buffer_size,
    input  logic [16:0] packet_size,
    input  logic        tick,
    input  logic        ar_accept,
    input  logic [31:0] burst_bytes,
    output logic [31:0] occupation,
    output logic        tick_ack
);

    logic [32:0] occ_plus_pkt;
    logic        add;

    assign occ_plus_pkt = {1'b0, occupation} + 33'(packet_size);
    // A tick that would overfill the ring is held off until reads make room.
    assign add = tick && !tick_ack && (occ_plus_pkt <= {1'b0, buffer_size});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occupation <= 32'd0;
            tick_ack   <= 1'b0;
        end else begin
            occupation <= occupation
                        + (add ? 32'(packet_size) : 32'd0)
                        - (ar_accept ? burst_bytes : 32'd0);
            if (add) begin
                tick_ack <= 1'b1;
            end else if (!tick) begin
                tick_ack <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tx_dmac.sv
// Ring-buffer DMA reader: issues AXI read bursts from DDR and streams beats out.
module tx_dmac
    import tx_dmac_pkg::*;
#(
    parameter int ADDR_W = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_enable,
    output logic [2:0]        read_state,
    output logic              read_error,
    input  logic [ADDR_W-1:0] buffer_base_address,
    input  logic [31:0]       buffer_size,
    input  logic [16:0]       buffer_packet_size_bytes,
    input  logic              buffer_packet_tick,
    output logic              buffer_packet_tick_ack,
    output logic [31:0]       buffer_occupation,
    input  logic [8:0]        burst_length_set,
    output logic [31:0]       burst_counter,
    input  logic              tx_fifo_space_ready,
    output logic [DATA_W-1:0] m_axis_tx_tdata,
    output logic              m_axis_tx_tvalid,
    input  logic              m_axis_tx_tready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; once asserted, arvalid and araddr hold until that edge.

    state_t            state;
    logic [8:0]        beat_idx;
    logic [31:0]       burst_bytes;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] ring_end;
    logic              ar_accept;
    logic              r_accept;
    logic              resp_err;

    assign burst_bytes = burst_bytes_of(burst_length_set);
    assign m_axi_arlen = 8'(burst_length_set - 9'd1);
    assign next_addr   = m_axi_araddr + ADDR_W'(burst_bytes);
    assign ring_end    = buffer_base_address + ADDR_W'(buffer_size);
    assign ar_accept   = m_axi_arvalid && m_axi_arready;

    // R channel is passed straight through to the stream; nothing is buffered.
    assign m_axi_rready     = (state == ST_DATA) && m_axis_tx_tready;
    assign m_axis_tx_tvalid = (state == ST_DATA) && m_axi_rvalid;
    assign m_axis_tx_tdata  = m_axi_rdata;
    assign r_accept         = m_axis_tx_tvalid && m_axi_rready;
    assign resp_err         = (m_axi_rresp == 2'b10) || (m_axi_rresp == 2'b11);
    assign read_state       = state;

    tx_dmac_occupancy u_occupancy (
        .clk         (clk),
        .rst_n       (rst_n),
        .buffer_size (buffer_size),
        .packet_size (buffer_packet_size_bytes),
        .tick        (buffer_packet_tick),
        .ar_accept   (ar_accept),
        .burst_bytes (burst_bytes),
        .occupation  (buffer_occupation),
        .tick_ack    (buffer_packet_tick_ack)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            m_axi_araddr  <= buffer_base_address;
            m_axi_arvalid <= 1'b0;
            burst_counter <= 32'd0;
            read_error    <= 1'b0;
            beat_idx      <= 9'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    m_axi_araddr  <= buffer_base_address;
                    burst_counter <= 32'd0;
                    read_error    <= 1'b0;
                    m_axi_arvalid <= 1'b0;
                    if (read_enable) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!read_enable) begin
                        state <= ST_IDLE;
                    end else if (buffer_occupation >= burst_bytes && tx_fifo_space_ready
                                 && !read_error) begin
                        m_axi_arvalid <= 1'b1;
                        state         <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ar_accept) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_araddr  <= (next_addr >= ring_end) ? buffer_base_address
                                                                 : next_addr;
                        beat_idx      <= 9'd0;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_accept) begin
                        beat_idx <= beat_idx + 9'd1;
                        // Errors are recorded but the burst keeps draining to rlast.
                        if (resp_err || (m_axi_rlast && beat_idx != {1'b0, m_axi_arlen})) begin
                            read_error <= 1'b1;
                        end
                        if (m_axi_rlast) begin
                            burst_counter <= burst_counter + 32'd1;
                            state         <= ST_CHECK;
                        end
                    end
                end
                default: begin
                    m_axi_arvalid <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
